// File: rtl/axil_timer_pkg.sv
// Shared constants and helpers for the AXI4-lite timer.
// Build option TIMER_PRESCALER_EN maps the PRESCALE register at 0x10.
package axil_timer_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_LOAD     = 8'h08;
  localparam logic [7:0] OFF_COUNT    = 8'h0C;
  localparam logic [7:0] OFF_PRESCALE = 8'h10;

  localparam int unsigned CTRL_ENABLE      = 0;
  localparam int unsigned CTRL_IRQ_EN      = 1;
  localparam int unsigned CTRL_AUTO_RELOAD = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] CTRL_RESET     = '0;
  localparam logic       PENDING_RESET  = 1'b0;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_LOAD,
    SEL_COUNT,
    SEL_PRESCALE,
    SEL_NONE
  } reg_sel_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  function automatic reg_sel_e decode(input logic [7:0] off);
    case (off)
      OFF_CTRL:     return SEL_CTRL;
      OFF_STATUS:   return SEL_STATUS;
      OFF_LOAD:     return SEL_LOAD;
      OFF_COUNT:    return SEL_COUNT;
`ifdef TIMER_PRESCALER_EN
      OFF_PRESCALE: return SEL_PRESCALE;
`endif
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axil_reg_port.sv
// AXI4-lite slave front end: independent AW/W holding registers, one
// outstanding write and one outstanding read, fixed single-cycle read latency.
module axil_reg_port
  import axil_timer_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  logic              live;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              aw_hs, w_hs;

  // live keeps every ready low until the first edge after reset release
  assign awready = live & ~aw_held & ~bvalid;
  assign wready  = live & ~w_held & ~bvalid;
  assign arready = live & ~rvalid;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  assign wr_en   = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_strb = w_held ? w_strb_q : wstrb;

  assign rd_en   = arvalid & arready;
  assign rd_addr = araddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      live <= 1'b1;
      if (wr_en) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
        if (bvalid && bready) bvalid <= 1'b0;
      end
      if (rd_en) begin
        rvalid <= 1'b1;
        rdata  <= rd_err ? '0 : rd_data;
        rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_timer.sv
// AXI4-lite down-counter timer with reload, one-shot/auto-reload and sticky IRQ.
// Build option TIMER_PRESCALER_EN adds a programmable tick prescaler.
module axil_timer
  import axil_timer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              rsi_resetn,
  input  logic              axs_awvalid,
  output logic              axs_awready,
  input  logic [ADDR_W-1:0] axs_awaddr,
  input  logic [2:0]        axs_awprot,
  input  logic              axs_wvalid,
  output logic              axs_wready,
  input  logic [31:0]       axs_wdata,
  input  logic [3:0]        axs_wstrb,
  output logic              axs_bvalid,
  input  logic              axs_bready,
  output logic [1:0]        axs_bresp,
  input  logic              axs_arvalid,
  output logic              axs_arready,
  input  logic [ADDR_W-1:0] axs_araddr,
  input  logic [2:0]        axs_arprot,
  output logic              axs_rvalid,
  input  logic              axs_rready,
  output logic [31:0]       axs_rdata,
  output logic [1:0]        axs_rresp,
  output logic              ins_irq
);

  logic              wr_en, rd_en, wr_err, rd_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data;
  logic [3:0]        wr_strb;

  axil_reg_port #(.ADDR_W(ADDR_W)) u_port (
    .clk(clk), .rst_n(rsi_resetn),
    .awvalid(axs_awvalid), .awready(axs_awready), .awaddr(axs_awaddr),
    .wvalid(axs_wvalid), .wready(axs_wready), .wdata(axs_wdata), .wstrb(axs_wstrb),
    .bvalid(axs_bvalid), .bready(axs_bready), .bresp(axs_bresp),
    .arvalid(axs_arvalid), .arready(axs_arready), .araddr(axs_araddr),
    .rvalid(axs_rvalid), .rready(axs_rready), .rdata(axs_rdata), .rresp(axs_rresp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_err(rd_err)
  );

  logic        enable, irq_en, auto_reload, pending;
  logic [31:0] load_q, count_q;
  reg_sel_e    wr_sel, rd_sel;
  logic        wr_ctrl, wr_status, wr_load, wr_count;
  logic [31:0] ctrl_new;
  logic        tick_raw, tick, expire;

  assign wr_sel = decode(8'({wr_addr[ADDR_W-1:2], 2'b00}));
  assign rd_sel = decode(8'({rd_addr[ADDR_W-1:2], 2'b00}));
  assign wr_err = (wr_sel == SEL_NONE);
  assign rd_err = (rd_sel == SEL_NONE);

  assign wr_ctrl   = wr_en && (wr_sel == SEL_CTRL);
  assign wr_status = wr_en && (wr_sel == SEL_STATUS);
  assign wr_load   = wr_en && (wr_sel == SEL_LOAD);
  assign wr_count  = wr_en && (wr_sel == SEL_COUNT);

  assign ctrl_new = apply_strb({29'b0, auto_reload, irq_en, enable}, wr_data, wr_strb);

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_q, presc_cnt;
  logic [31:0]           presc_new;
  logic                  wr_prescale;

  assign wr_prescale = wr_en && (wr_sel == SEL_PRESCALE);
  assign presc_new   = apply_strb(32'(prescale_q), wr_data, wr_strb);
  assign tick_raw    = enable && (presc_cnt == prescale_q);

  always_ff @(posedge clk or negedge rsi_resetn) begin
    if (!rsi_resetn) begin
      prescale_q <= '0;
      presc_cnt  <= '0;
    end else begin
      if (wr_prescale) prescale_q <= presc_new[PRESCALE_W-1:0];
      if (!enable || wr_prescale || presc_cnt == prescale_q) presc_cnt <= '0;
      else presc_cnt <= presc_cnt + 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{axs_awprot, axs_arprot, wr_addr[1:0], rd_addr[1:0],
                         ctrl_new[31:3], presc_new};
`else
  assign tick_raw = enable;

  logic unused_bits;
  assign unused_bits = ^{axs_awprot, axs_arprot, wr_addr[1:0], rd_addr[1:0],
                         ctrl_new[31:3], PRESCALE_W};
`endif

  // a CTRL write that clears ENABLE suppresses the tick of the same cycle
  assign tick   = tick_raw && !(wr_ctrl && !ctrl_new[CTRL_ENABLE]);
  assign expire = tick && (count_q == '0);

  always_ff @(posedge clk or negedge rsi_resetn) begin
    if (!rsi_resetn) begin
      {auto_reload, irq_en, enable} <= CTRL_RESET;
      pending <= PENDING_RESET;
      load_q  <= RESET_LOAD;
      count_q <= RESET_LOAD;
    end else begin
      if (wr_ctrl) begin
        enable      <= ctrl_new[CTRL_ENABLE];
        irq_en      <= ctrl_new[CTRL_IRQ_EN];
        auto_reload <= ctrl_new[CTRL_AUTO_RELOAD];
      end else if (expire && !auto_reload) begin
        enable <= 1'b0;
      end

      if (expire) pending <= 1'b1;
      else if (wr_status && wr_strb[0] && wr_data[0]) pending <= 1'b0;

      if (wr_load) load_q <= apply_strb(load_q, wr_data, wr_strb);

      if (wr_count) count_q <= apply_strb(count_q, wr_data, wr_strb);
      else if (tick) begin
        if (count_q != '0) count_q <= count_q - 1'b1;
        else if (auto_reload) count_q <= load_q;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_CTRL:     rd_data = {29'b0, auto_reload, irq_en, enable};
      SEL_STATUS:   rd_data = {31'b0, pending};
      SEL_LOAD:     rd_data = load_q;
      SEL_COUNT:    rd_data = count_q;
`ifdef TIMER_PRESCALER_EN
      SEL_PRESCALE: rd_data = 32'(prescale_q);
`endif
      default:      rd_data = '0;
    endcase
  end

  assign ins_irq = pending & irq_en;

endmodule

// File: tb/tb_axil_timer.sv
// Randomised self-checking bench for axil_timer against a cycle-level
// behavioural model of the register map and counter rules.
module tb_axil_timer;

`ifdef TIMER_PRESCALER_EN
  localparam bit PS_EN = 1'b1;
`else
  localparam bit PS_EN = 1'b0;
`endif

  logic        clk, rsi_resetn;
  logic        axs_awvalid, axs_awready, axs_wvalid, axs_wready;
  logic [4:0]  axs_awaddr, axs_araddr;
  logic [2:0]  axs_awprot, axs_arprot;
  logic [31:0] axs_wdata, axs_rdata;
  logic [3:0]  axs_wstrb;
  logic        axs_bvalid, axs_bready, axs_arvalid, axs_arready;
  logic        axs_rvalid, axs_rready, ins_irq;
  logic [1:0]  axs_bresp, axs_rresp;

  axil_timer #(.ADDR_W(5), .RESET_LOAD(32'hFFFF_FFFF), .PRESCALE_W(16)) dut (
    .clk(clk), .rsi_resetn(rsi_resetn),
    .axs_awvalid(axs_awvalid), .axs_awready(axs_awready), .axs_awaddr(axs_awaddr),
    .axs_awprot(axs_awprot), .axs_wvalid(axs_wvalid), .axs_wready(axs_wready),
    .axs_wdata(axs_wdata), .axs_wstrb(axs_wstrb), .axs_bvalid(axs_bvalid),
    .axs_bready(axs_bready), .axs_bresp(axs_bresp), .axs_arvalid(axs_arvalid),
    .axs_arready(axs_arready), .axs_araddr(axs_araddr), .axs_arprot(axs_arprot),
    .axs_rvalid(axs_rvalid), .axs_rready(axs_rready), .axs_rdata(axs_rdata),
    .axs_rresp(axs_rresp), .ins_irq(ins_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_en, m_ie, m_ar, m_pend;
  logic [31:0] m_load, m_count, m_ps, m_pc;
  logic [33:0] rd_exp_q[$];
  logic [1:0]  b_exp_q[$];
  bit          p_aw, p_w;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_strb;
  bit          s_aw, s_w, s_ar;
  logic [4:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = n[b*8 +: 8];
    return m;
  endfunction

  function automatic bit reg_ok(input int word);
    return (word >= 0 && word <= 3) || (PS_EN && word == 4);
  endfunction

  function automatic logic [33:0] model_read(input logic [4:0] a);
    case (int'(a[4:2]))
      0: return {2'b00, 29'b0, m_ar, m_ie, m_en};
      1: return {2'b00, 31'b0, m_pend};
      2: return {2'b00, m_load};
      3: return {2'b00, m_count};
      4: return PS_EN ? {2'b00, m_ps} : {2'b10, 32'b0};
      default: return {2'b10, 32'b0};
    endcase
  endfunction

  task automatic model_reset();
    {m_en, m_ie, m_ar, m_pend} = '0;
    m_load = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    m_ps = 0;
    m_pc = 0;
    p_aw = 0;
    p_w = 0;
    rd_exp_q.delete();
    b_exp_q.delete();
  endtask

  task automatic model_step();
    int word;
    logic [31:0] d, c_new, n_count, n_load, n_ps, n_pc;
    logic [3:0]  s;
    bit tick, fire, n_en, n_ie, n_ar, n_pend;
    if (s_ar) rd_exp_q.push_back(model_read(s_araddr));
    if (s_aw) begin p_aw = 1; p_addr = s_awaddr; end
    if (s_w) begin p_w = 1; p_data = s_wdata; p_strb = s_wstrb; end
    word = -1;
    d = p_data;
    s = p_strb;
    if (p_aw && p_w) begin
      word = int'(p_addr[4:2]);
      b_exp_q.push_back(reg_ok(word) ? 2'b00 : 2'b10);
      p_aw = 0;
      p_w = 0;
    end
    tick = m_en && (m_pc == m_ps);
    c_new = merge({29'b0, m_ar, m_ie, m_en}, d, s);
    if (word == 0 && !c_new[0]) tick = 0;
    fire = tick && (m_count == 0);
    {n_en, n_ie, n_ar, n_pend} = {m_en, m_ie, m_ar, m_pend};
    n_count = m_count; n_load = m_load; n_ps = m_ps;
    if (tick) n_count = (m_count != 0) ? m_count - 1 : (m_ar ? m_load : 32'd0);
    if (fire) begin n_pend = 1; if (!m_ar) n_en = 0; end
    if (word == 0) {n_ar, n_ie, n_en} = c_new[2:0];
    if (word == 1 && s[0] && d[0] && !fire) n_pend = 0;
    if (word == 2) n_load = merge(m_load, d, s);
    if (word == 3) n_count = merge(m_count, d, s);
    if (PS_EN && word == 4) n_ps = merge(m_ps, d, s) & 32'h0000_FFFF;
    n_pc = (!m_en || (PS_EN && word == 4) || m_pc == m_ps) ? 32'd0 : m_pc + 1;
    {m_en, m_ie, m_ar, m_pend} = {n_en, n_ie, n_ar, n_pend};
    m_count = n_count; m_load = n_load; m_ps = n_ps; m_pc = n_pc;
  endtask

  always @(negedge clk) begin
    #2;
    s_aw = axs_awvalid && axs_awready;
    s_w  = axs_wvalid && axs_wready;
    s_ar = axs_arvalid && axs_arready;
    s_awaddr = axs_awaddr;
    s_wdata  = axs_wdata;
    s_wstrb  = axs_wstrb;
    s_araddr = axs_araddr;
  end

  always @(posedge clk) begin
    if (!rsi_resetn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rsi_resetn) check("irq", ins_irq, m_pend && m_ie);
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lag, input int w_lag, input int b_lag,
                           output logic [1:0] resp);
    int cyc = 0;
    bit aw_done = 0, w_done = 0;
    logic [1:0] exp;
    axs_awaddr = a; axs_wdata = d; axs_wstrb = s;
    axs_awprot = 3'($urandom);
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge clk);
      axs_awvalid = !aw_done && cyc >= aw_lag;
      axs_wvalid  = !w_done && cyc >= w_lag;
      if (axs_awvalid && axs_awready) aw_done = 1;
      if (axs_wvalid && axs_wready) w_done = 1;
      cyc++;
    end
    check("wr_accept", aw_done && w_done, 1'b1);
    @(negedge clk);
    axs_awvalid = 0; axs_wvalid = 0;
    check("bvalid_latency", axs_bvalid, 1'b1);
    exp = (b_exp_q.size() != 0) ? b_exp_q.pop_front() : 2'bxx;
    for (int i = 0; i < b_lag; i++) begin
      check("b_stall", {axs_bvalid, axs_awready, axs_wready, axs_bresp}, {3'b100, exp});
      @(negedge clk);
    end
    axs_bready = 1;
    resp = axs_bresp;
    check("bresp", {axs_bvalid, axs_bresp}, {1'b1, exp});
    @(negedge clk);
    axs_bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int r_lag,
                          output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    logic [33:0] exp;
    @(negedge clk);
    axs_araddr = a; axs_arvalid = 1; axs_arprot = 3'($urandom);
    while (!axs_arready && n < 50) begin @(negedge clk); n++; end
    check("ar_accept", axs_arready, 1'b1);
    @(negedge clk);
    axs_arvalid = 0;
    check("rvalid_latency", axs_rvalid, 1'b1);
    exp = (rd_exp_q.size() != 0) ? rd_exp_q.pop_front() : 34'bx;
    for (int i = 0; i < r_lag; i++) begin
      @(negedge clk);
      check("r_stall", {axs_rvalid, axs_rresp, axs_rdata}, {1'b1, exp});
    end
    axs_rready = 1;
    d = axs_rdata; r = axs_rresp;
    check("rdata", {r, d}, exp);
    @(negedge clk);
    axs_rready = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd;
  logic [1:0]  rr, br;

  initial begin
    rsi_resetn = 0;
    {axs_awvalid, axs_wvalid, axs_bready, axs_arvalid, axs_rready} = '0;
    axs_awaddr = '0; axs_araddr = '0; axs_wdata = '0; axs_wstrb = '0;
    axs_awprot = '0; axs_arprot = '0;
    idle(3);
    check("reset_outputs",
          {axs_awready, axs_wready, axs_arready, axs_bvalid, axs_rvalid,
           axs_bresp, axs_rresp, axs_rdata, ins_irq}, 64'd0);
    rsi_resetn = 1;
    #1 check("ready_low_at_release", {axs_awready, axs_wready, axs_arready}, 3'b000);
    idle(1);
    check("ready_after_release", {axs_awready, axs_wready, axs_arready}, 3'b111);

    axi_read(5'h0C, 0, rd, rr);
    check("count_reset", {rr, rd}, {2'b00, 32'hFFFF_FFFF});

    // auto-reload run with period LOAD+1
    axi_write(5'h08, 32'd3, 4'hF, 0, 0, 0, br);
    axi_write(5'h0C, 32'd3, 4'hF, 0, 0, 0, br);
    axi_write(5'h00, 32'd7, 4'hF, 0, 0, 0, br);
    for (int i = 0; i < 6; i++) axi_read(5'h0C, 0, rd, rr);
    axi_read(5'h04, 0, rd, rr);
    check("pending_after_reload", rd, 32'd1);
    axi_write(5'h04, 32'd1, 4'hF, 0, 0, 0, br);
    idle(2);

    // AW leads W by three cycles, B stalled two cycles
    axi_write(5'h08, 32'h0000_0005, 4'hF, 0, 3, 2, br);
    axi_read(5'h08, 0, rd, rr);
    check("load_after_split_write", rd, 32'd5);

    // unmapped accesses
    axi_read(5'h18, 1, rd, rr);
    check("unmapped_read", {rr, rd}, {2'b10, 32'd0});
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, br);
    check("unmapped_write_resp", br, 2'b10);
    for (int w = 0; w < 4; w++) axi_read(5'(w * 4), 0, rd, rr);

    // W1C racing counter events with a two-cycle period
    axi_write(5'h08, 32'd1, 4'hF, 0, 0, 0, br);
    for (int i = 0; i < 6; i++) begin
      axi_write(5'h04, 32'd1, 4'h1, 0, 0, 0, br);
      axi_read(5'h04, 0, rd, rr);
    end
    // COUNT writes while every cycle is a tick
    for (int i = 0; i < 4; i++) begin
      axi_write(5'h0C, 32'($urandom_range(20, 200)), 4'hF, 0, 0, 0, br);
      axi_read(5'h0C, 0, rd, rr);
    end

    // one-shot
    axi_write(5'h00, 32'd0, 4'hF, 0, 0, 0, br);
    axi_write(5'h04, 32'd1, 4'hF, 0, 0, 0, br);
    axi_write(5'h0C, 32'd2, 4'hF, 0, 0, 0, br);
    axi_write(5'h00, 32'd3, 4'hF, 0, 0, 0, br);
    idle(8);
    axi_read(5'h00, 0, rd, rr);
    check("oneshot_ctrl", rd, 32'd2);
    axi_read(5'h0C, 0, rd, rr);
    check("oneshot_count", rd, 32'd0);
    axi_write(5'h04, 32'd1, 4'hF, 0, 0, 0, br);
    idle(6);
    axi_read(5'h04, 0, rd, rr);
    check("oneshot_no_refire", rd, 32'd0);

`ifdef TIMER_PRESCALER_EN
    axi_write(5'h10, 32'd4, 4'hF, 0, 0, 0, br);
    axi_write(5'h0C, 32'd20, 4'hF, 0, 0, 0, br);
    axi_write(5'h00, 32'd5, 4'hF, 0, 0, 0, br);
    for (int i = 0; i < 8; i++) begin
      idle(3);
      axi_read(5'h0C, 0, rd, rr);
    end
    axi_read(5'h10, 0, rd, rr);
    check("prescale_readback", rd, 32'd4);
`endif

    // random traffic
    for (int i = 0; i < 60; i++) begin
      logic [4:0] a;
      logic [31:0] d;
      a = 5'({3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))});
      d = $urandom_range(0, 1) ? 32'($urandom_range(0, 12)) : $urandom;
      if ($urandom_range(0, 1) != 0)
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), br);
      else
        axi_read(a, $urandom_range(0, 2), rd, rr);
      idle($urandom_range(0, 3));
    end
    for (int w = 0; w < 5; w++) axi_read(5'(w * 4), 0, rd, rr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
